dsp48a1_mac_ctrl: RTL and testbench
===================================

DSP48A1_MAC_CTRL -- requirements
Module: dsp48a1_mac_ctrl

Interface
REQ-001 Parameter WIDTH, 18, operand width of A and B.
REQ-002 Parameter LEN_W, 8, width of the product-count field.
REQ-003 Parameter PIPE_LAT, 4, clk edges from a dsp_a/dsp_b/opmode update until dsp_p reflects that operation.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  command strobe; sampled only in IDLE.
REQ-007 len  in  LEN_W  number of products to accumulate; latched with start.
REQ-008 in_valid  in  1  operand pair a_in/b_in is valid.
REQ-009 in_ready  out  1  block accepts operands; transfer occurs when in_valid and in_ready are both 1 at an edge.
REQ-010 a_in, b_in  in  WIDTH  signed operands.
REQ-011 dsp_a, dsp_b  out  WIDTH  registered operands to the DSP slice.
REQ-012 opmode  out  8  registered DSP48A1 OPMODE.
REQ-013 ce  out  1  DSP clock enable.
REQ-014 dsp_p  in  48  DSP P output.
REQ-015 result  out  48  captured signed sum of products.
REQ-016 busy  out  1  high in ACCUM and DRAIN.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have four states: IDLE, ACCUM, DRAIN, DONE.
REQ-019 IDLE: in_ready=0, ce=0, opmode=0x00; start=1 with len!=0 -> ACCUM, counter<=len, first flag<=1; start=1 with len==0 -> DONE with result<=0 and no DSP activity.
REQ-020 ACCUM: in_ready=1, ce=1; on transfer, dsp_a<=a_in, dsp_b<=b_in, opmode<=0x01 (P=A*B) if first flag else 0x09 (P=P+A*B); first flag<=0; counter decrements.
REQ-021 ACCUM without transfer: opmode<=0x08 (P=P+0 bubble); dsp_a/dsp_b hold.
REQ-022 Transfer with counter==1 -> DRAIN, drain counter<=PIPE_LAT, in_ready=0 from the next cycle.
REQ-023 DRAIN: ce=1, opmode=0x08; drain counter decrements each cycle; at the edge where it is 0, result<=dsp_p -> DONE (DRAIN lasts PIPE_LAT+1 cycles).
REQ-024 DONE: done=1 for exactly one cycle, busy=0, ce=0; unconditional -> IDLE.
REQ-025 start and len SHALL be ignored outside IDLE; len is not re-sampled mid-operation.
REQ-026 result holds its value until the next capture; arithmetic wraps modulo 2^48 (performed by the DSP, no saturation).
REQ-027 Latency with back-to-back operands: done is high in the cycle after edge start+N+PIPE_LAT+1, where N=len.
REQ-028 len=2^LEN_W-1 SHALL complete correctly with no counter overflow.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, in_ready=0, busy=0, done=0, ce=0, opmode=0x00, dsp_a=0, dsp_b=0, result=0, all counters 0, first flag 0.
REQ-030 rst asserted mid-ACCUM or mid-DRAIN SHALL abort the operation with no done pulse; the first start after release begins a fresh accumulation.

Verification (DSP behavioural model, PIPE_LAT=4)
REQ-031 len=3, back-to-back pairs (2,3),(4,5),(-1,6) -> opmode 0x01,0x09,0x09, then 0x08 for 5 DRAIN cycles; result=20; single done pulse 8 edges after start; in_ready low after the 3rd transfer.
REQ-032 len=2, pairs (7,-3),(10,10), with 3 idle in_valid cycles between -> opmode 0x08 during the gap; result=79.
REQ-033 len=0 -> DONE in the next cycle, result=0, ce never asserted.
REQ-034 start=1 with len=5 pulsed during ACCUM of a len=2 job -> ignored; result reflects 2 products; exactly one done pulse.
REQ-035 rst low for 1 cycle after the 2nd transfer of len=4 -> all outputs 0 asynchronously, no done pulse; new len=1 job (3,3) -> result=9.
REQ-036 len=255, every pair (1,1) -> result=255; done after 255+PIPE_LAT+1 edges.

Source files
------------

// File: rtl/dsp48a1_mac_ctrl.sv
// dsp48a1_mac_ctrl
// Sequences a multiply-accumulate job on a DSP48A1 slice: streams operand
// pairs into the slice, picks the OPMODE for each cycle, waits for the
// slice pipeline to flush and captures the accumulated P value.

module dsp48a1_mac_ctrl #(
  parameter int WIDTH    = 18,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] dsp_a,
  output logic signed [WIDTH-1:0] dsp_b,
  output logic [7:0]              opmode,
  output logic                    ce,
  input  logic [47:0]             dsp_p,
  output logic [47:0]             result,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] OP_ZERO = 8'h00;
  localparam logic [7:0] OP_MUL  = 8'h01;
  localparam logic [7:0] OP_HOLD = 8'h08;
  localparam logic [7:0] OP_MAC  = 8'h09;

  logic [1:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             first;
  logic             xfer;

  // Status and handshake outputs are pure decodes of the current state.
  always_comb begin
    in_ready = (state == S_ACCUM);
    busy     = (state == S_ACCUM) || (state == S_DRAIN);
    ce       = busy;
    done     = (state == S_DONE);
    xfer     = in_valid && in_ready;
  end

  // Main sequencer: operand registers, OPMODE selection, product and drain
  // counting, and capture of the slice output once its pipeline has flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dcnt   <= '0;
      first  <= 1'b0;
      dsp_a  <= '0;
      dsp_b  <= '0;
      opmode <= OP_ZERO;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          opmode <= OP_ZERO;
          if (start) begin
            if (len != '0) begin
              state <= S_ACCUM;
              cnt   <= len;
              first <= 1'b1;
            end else begin
              state  <= S_DONE;
              result <= '0;
            end
          end
        end
        S_ACCUM: begin
          if (xfer) begin
            dsp_a  <= a_in;
            dsp_b  <= b_in;
            opmode <= first ? OP_MUL : OP_MAC;
            first  <= 1'b0;
            cnt    <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= S_DRAIN;
              dcnt  <= DW'(PIPE_LAT);
            end
          end else begin
            opmode <= OP_HOLD;
          end
        end
        S_DRAIN: begin
          opmode <= OP_HOLD;
          if (dcnt == '0) begin
            result <= dsp_p;
            state  <= S_DONE;
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        S_DONE: begin
          opmode <= OP_ZERO;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb_dsp48a1_mac_ctrl
// Drives directed and random MAC jobs into the controller, models the DSP48A1
// slice as a PIPE_LAT-deep pipeline, and checks results against plain sums.

module tb_dsp48a1_mac_ctrl;

  localparam int WIDTH    = 18;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_in;
  logic signed [WIDTH-1:0] b_in;
  logic signed [WIDTH-1:0] dsp_a;
  logic signed [WIDTH-1:0] dsp_b;
  logic [7:0]              opmode;
  logic                    ce;
  logic [47:0]             dsp_p;
  logic [47:0]             result;
  logic                    busy;
  logic                    done;

  int testsRun    = 0;
  int testsFailed = 0;

  int qa[$];
  int qb[$];
  int qg[$];
  logic [7:0] opLog [0:511];
  logic       rdyLog [0:511];
  bit         ceEver;

  dsp48a1_mac_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .opmode(opmode), .ce(ce),
    .dsp_p(dsp_p), .result(result), .busy(busy), .done(done)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // DSP slice model: operands are sampled one edge after they appear and the
  // P register reflects them PIPE_LAT edges after the controller updates them.
  logic [7:0]              s1o = '0, s2o = '0, s3o = '0;
  logic signed [WIDTH-1:0] s1a = '0, s2a = '0, s3a = '0;
  logic signed [WIDTH-1:0] s1b = '0, s2b = '0, s3b = '0;
  logic [47:0]             pReg = '0;
  longint                  prod3;
  assign dsp_p = pReg;
  assign prod3 = longint'(s3a) * longint'(s3b);

  always @(posedge clk) begin
    if (ce) begin
      s1o <= opmode; s1a <= dsp_a; s1b <= dsp_b;
      s2o <= s1o;    s2a <= s1a;   s2b <= s1b;
      s3o <= s2o;    s3a <= s2a;   s3b <= s2b;
      case (s3o)
        8'h00:   pReg <= '0;
        8'h01:   pReg <= prod3[47:0];
        8'h09:   pReg <= pReg + prod3[47:0];
        default: pReg <= pReg;
      endcase
    end
  end

  // Reference: the accumulated value is just the sum of products modulo 2^48.
  function automatic logic [47:0] refSum();
    longint s = 0;
    foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
    return s[47:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job using qa/qb (operands) and qg (idle cycles before each pair).
  // Edge 0 is the start edge; doneEdge is the edge after which done was seen.
  task automatic applyStimulus(input int n, input bit injectStart,
                               output int doneEdge, output int doneCount, output int lastXfer);
    int  idx = 0;
    int  e = 0;
    int  gapLeft;
    int  budget;
    bit  pend;
    budget    = 8 * n + 200;
    doneEdge  = -1;
    doneCount = 0;
    lastXfer  = 0;
    ceEver    = 1'b0;
    gapLeft   = (n > 0) ? qg[0] : 0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); in_valid = 1'b0;
    @(posedge clk);
    while (e < budget && !(doneEdge >= 0 && e >= doneEdge + 3)) begin
      @(negedge clk);
      if (e < 512) begin opLog[e] = opmode; rdyLog[e] = in_ready; end
      if (ce) ceEver = 1'b1;
      if (done) begin doneCount++; if (doneEdge < 0) doneEdge = e; end
      start    = injectStart && (e == 1);
      len      = injectStart ? LEN_W'(5) : LEN_W'(n);
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
      pend     = 1'b0;
      if (in_ready && idx < n) begin
        if (gapLeft > 0) gapLeft--;
        else begin
          in_valid = 1'b1; a_in = WIDTH'(qa[idx]); b_in = WIDTH'(qb[idx]); pend = 1'b1;
        end
      end
      @(posedge clk);
      e++;
      if (pend) begin
        idx++;
        lastXfer = e;
        gapLeft  = (idx < n) ? qg[idx] : 0;
      end
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic fillJob(input int n, input int gapMax);
    qa.delete(); qb.delete(); qg.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1)));
      qb.push_back(int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1)));
      qg.push_back((i == 0) ? 0 : int'($urandom_range(0, gapMax)));
    end
  endtask

  initial begin
    int dEdge, dCount, lastX, n, cnt;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a_in = '0; b_in = '0;
    #3 rst = 1'b0;
    #5;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_busy",     64'(busy),     64'd0);
    checkOutput("reset_ce",       64'(ce),       64'd0);
    checkOutput("reset_opmode",   64'(opmode),   64'd0);
    checkOutput("reset_result",   64'(result),   64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Three back-to-back pairs.
    qa = '{2, 4, -1}; qb = '{3, 5, 6}; qg = '{0, 0, 0};
    applyStimulus(3, 1'b0, dEdge, dCount, lastX);
    checkOutput("j3_result",    64'(result),  64'(refSum()));
    checkOutput("j3_done_edge", 64'(dEdge),   64'(3 + PIPE_LAT + 1));
    checkOutput("j3_done_cnt",  64'(dCount),  64'd1);
    checkOutput("j3_op1",       64'(opLog[1]), 64'h01);
    checkOutput("j3_op2",       64'(opLog[2]), 64'h09);
    checkOutput("j3_op3",       64'(opLog[3]), 64'h09);
    for (int i = 4; i <= 7; i++) checkOutput("j3_op_drain", 64'(opLog[i]), 64'h08);
    checkOutput("j3_rdy_before", 64'(rdyLog[2]), 64'd1);
    checkOutput("j3_rdy_after",  64'(rdyLog[3]), 64'd0);

    // Two pairs with a three-cycle gap between them.
    qa = '{7, 10}; qb = '{-3, 10}; qg = '{0, 3};
    applyStimulus(2, 1'b0, dEdge, dCount, lastX);
    checkOutput("gap_result",    64'(result), 64'(refSum()));
    checkOutput("gap_result_79", 64'(result), 64'd79);
    for (int i = 2; i <= 4; i++) checkOutput("gap_op_bubble", 64'(opLog[i]), 64'h08);
    checkOutput("gap_done_edge", 64'(dEdge), 64'(lastX + PIPE_LAT + 1));

    // Zero-length job.
    qa.delete(); qb.delete(); qg.delete();
    applyStimulus(0, 1'b0, dEdge, dCount, lastX);
    checkOutput("len0_result",    64'(result), 64'd0);
    checkOutput("len0_done_edge", 64'(dEdge),  64'd0);
    checkOutput("len0_done_cnt",  64'(dCount), 64'd1);
    checkOutput("len0_ce",        64'(ceEver), 64'd0);

    // Start strobe during accumulation must be ignored.
    qa = '{-9, 11}; qb = '{8, 12}; qg = '{0, 0};
    applyStimulus(2, 1'b1, dEdge, dCount, lastX);
    checkOutput("inj_result",   64'(result), 64'(refSum()));
    checkOutput("inj_done_cnt", 64'(dCount), 64'd1);
    repeat (12) begin
      @(negedge clk);
      if (done) dCount++;
    end
    checkOutput("inj_no_rerun", 64'(dCount), 64'd1);

    // Random jobs with random operands and gaps.
    for (int j = 0; j < 6; j++) begin
      n = int'($urandom_range(1, 6));
      fillJob(n, 2);
      applyStimulus(n, 1'b0, dEdge, dCount, lastX);
      checkOutput("rand_result",    64'(result), 64'(refSum()));
      checkOutput("rand_done_edge", 64'(dEdge),  64'(lastX + PIPE_LAT + 1));
      checkOutput("rand_done_cnt",  64'(dCount), 64'd1);
    end

    // Maximum length job.
    qa.delete(); qb.delete(); qg.delete();
    for (int i = 0; i < 255; i++) begin qa.push_back(1); qb.push_back(1); qg.push_back(0); end
    applyStimulus(255, 1'b0, dEdge, dCount, lastX);
    checkOutput("max_result",    64'(result), 64'd255);
    checkOutput("max_done_edge", 64'(dEdge),  64'(255 + PIPE_LAT + 1));
    checkOutput("max_done_cnt",  64'(dCount), 64'd1);

    // Asynchronous reset after the second transfer of a four-pair job.
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_in = 18'sd5; b_in = 18'sd6;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("arst_busy",     64'(busy),     64'd0);
    checkOutput("arst_done",     64'(done),     64'd0);
    checkOutput("arst_ce",       64'(ce),       64'd0);
    checkOutput("arst_opmode",   64'(opmode),   64'd0);
    checkOutput("arst_dsp_a",    64'(dsp_a),    64'd0);
    checkOutput("arst_dsp_b",    64'(dsp_b),    64'd0);
    checkOutput("arst_result",   64'(result),   64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("arst_no_done",  64'(cnt),    64'd0);
    checkOutput("arst_hold_res", 64'(result), 64'd0);

    qa = '{3}; qb = '{3}; qg = '{0};
    applyStimulus(1, 1'b0, dEdge, dCount, lastX);
    checkOutput("post_rst_result",    64'(result), 64'd9);
    checkOutput("post_rst_done_edge", 64'(dEdge),  64'(1 + PIPE_LAT + 1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
